alu_op_sequencer: RTL and testbench
===================================

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter N_OPS, default 15, number of one-hot ALU operation strobes driven.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 clr  in  1  reset, asynchronous, active-low.
REQ-004 start  in  1  request to execute one ALU instruction; sampled only in IDLE.
REQ-005 opcode  in  5  ALU instruction code, captured with start.
REQ-006 busy  out  1  high from the cycle after start acceptance until DONE exits.
REQ-007 done  out  1  one-cycle pulse, instruction complete.
REQ-008 err  out  1  one-cycle pulse, illegal opcode rejected.
REQ-009 alu_op  out  N_OPS  one-hot strobe, bit order ADD,SUB,AND,OR,SHR,SHRA,SHL,ROR,ROL,NEG,NOT,MUL,DIV,INCPC,BRANCH (bit 0 = ADD).
REQ-010 gra, grb, grc  out  1 each  register-field select for the bus (rA, rB, rC).
REQ-011 rout, rin  out  1 each  selected general register drives bus / loads from bus.
REQ-012 yin, zin, zlowout, zhighout, loin, hiin  out  1 each  Y/Z/LO/HI datapath controls.

Function
REQ-013 States SHALL be IDLE, T_Y, T_OP, T_ZLO, T_ZHI, DONE, ERR; encoding is implementation choice.
REQ-014 In IDLE with start=1 the opcode SHALL be latched; legal -> T_Y, illegal -> ERR; start in any other state SHALL be ignored.
REQ-015 Classes: BINARY (ADD..ROL), UNARY (NEG, NOT), WIDE (MUL, DIV); INCPC and BRANCH SHALL be illegal at this block (driven by the fetch sequencer).
REQ-016 T_Y: BINARY asserts grb,rout,yin; UNARY asserts grb,rout,yin; WIDE asserts gra,rout,yin.
REQ-017 T_OP: exactly one alu_op bit for the latched opcode plus zin; BINARY asserts grc,rout; WIDE asserts grb,rout; UNARY drives no bus source.
REQ-018 T_ZLO: zlowout plus gra,rin for BINARY/UNARY, plus loin for WIDE; WIDE -> T_ZHI, others -> DONE.
REQ-019 T_ZHI: zhighout, hiin; -> DONE.
REQ-020 DONE: done=1 one cycle -> IDLE; ERR: err=1 one cycle, no datapath strobe -> IDLE.
REQ-021 Latency: start accepted at edge k -> done high in cycle k+4 (BINARY/UNARY) or k+5 (WIDE); next start accepted at edge after DONE.
REQ-022 Outputs SHALL be decoded solely from registered state and latched opcode (Moore); alu_op SHALL be all-zero outside T_OP.
REQ-023 At most one of {rout, zlowout, zhighout} SHALL be high in any cycle; at most one of gra/grb/grc.
REQ-024 busy SHALL be high in T_Y..DONE and ERR, low in IDLE.

Reset
REQ-025 clr=0 SHALL force IDLE immediately, every output 0, latched opcode 0, regardless of state (including mid-instruction).
REQ-026 After clr deasserts, first start SHALL be sampled at the first rising edge with clr=1.

Structure
REQ-027 Shared package alu_seq_pkg SHALL hold opcode constants (ADD=0x00, SUB=0x01, AND=0x02, OR=0x03, SHR=0x04, SHRA=0x05, SHL=0x06, ROR=0x07, ROL=0x08, NEG=0x09, NOT=0x0A, MUL=0x0B, DIV=0x0C), alu_op bit indices, state encoding.
REQ-028 One sub-module alu_op_decode SHALL map opcode to {one-hot alu_op, class, legal}, combinational.

Verification
REQ-029 ADD (0x00), start at cycle 0 -> T_Y grb/rout/yin c1, alu_op=15'h0001+zin+grc/rout c2, zlowout/gra/rin c3, done c4.
REQ-030 MUL (0x0B) -> alu_op bit 11 in T_OP, loin with zlowout c3, hiin with zhighout c4, done c5, never rin.
REQ-031 NOT (0x0A) -> T_OP has alu_op bit 10, zin, rout=0; done c4.
REQ-032 Opcode 0x1F -> err pulse c1, all datapath strobes 0, busy c1 only, IDLE c2.
REQ-033 start held high continuously with ADD -> instructions complete every 5 cycles, no start accepted while busy.
REQ-034 clr pulled low during T_OP of DIV -> all outputs 0 same cycle, IDLE, no done/hiin; subsequent SUB completes normally.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared constants for the ALU operation sequencer: opcodes, strobe bit
// positions, instruction classes and FSM states.
package alu_seq_pkg;

  localparam int unsigned OPC_W = 5;

  // ALU instruction codes handled by this block
  localparam logic [OPC_W-1:0] OP_ADD  = 5'h00;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'h01;
  localparam logic [OPC_W-1:0] OP_AND  = 5'h02;
  localparam logic [OPC_W-1:0] OP_OR   = 5'h03;
  localparam logic [OPC_W-1:0] OP_SHR  = 5'h04;
  localparam logic [OPC_W-1:0] OP_SHRA = 5'h05;
  localparam logic [OPC_W-1:0] OP_SHL  = 5'h06;
  localparam logic [OPC_W-1:0] OP_ROR  = 5'h07;
  localparam logic [OPC_W-1:0] OP_ROL  = 5'h08;
  localparam logic [OPC_W-1:0] OP_NEG  = 5'h09;
  localparam logic [OPC_W-1:0] OP_NOT  = 5'h0A;
  localparam logic [OPC_W-1:0] OP_MUL  = 5'h0B;
  localparam logic [OPC_W-1:0] OP_DIV  = 5'h0C;

  // Bit positions inside the one-hot alu_op strobe
  localparam int unsigned BIT_ADD    = 0;
  localparam int unsigned BIT_SUB    = 1;
  localparam int unsigned BIT_AND    = 2;
  localparam int unsigned BIT_OR     = 3;
  localparam int unsigned BIT_SHR    = 4;
  localparam int unsigned BIT_SHRA   = 5;
  localparam int unsigned BIT_SHL    = 6;
  localparam int unsigned BIT_ROR    = 7;
  localparam int unsigned BIT_ROL    = 8;
  localparam int unsigned BIT_NEG    = 9;
  localparam int unsigned BIT_NOT    = 10;
  localparam int unsigned BIT_MUL    = 11;
  localparam int unsigned BIT_DIV    = 12;
  localparam int unsigned BIT_INCPC  = 13;  // owned by the fetch sequencer
  localparam int unsigned BIT_BRANCH = 14;  // owned by the fetch sequencer

  typedef enum logic [1:0] {
    CLS_BINARY,
    CLS_UNARY,
    CLS_WIDE
  } op_class_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_T_Y,
    S_T_OP,
    S_T_ZLO,
    S_T_ZHI,
    S_DONE,
    S_ERR
  } state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decoder: one-hot ALU strobe, instruction class, legality.
import alu_seq_pkg::*;

module alu_op_decode #(
  parameter int unsigned N_OPS = 15
) (
  input  logic [OPC_W-1:0] opcode,
  output logic [N_OPS-1:0] alu_op,
  output op_class_e        op_class,
  output logic             legal
);

  // Map each legal opcode to its strobe bit and class; anything else is illegal
  always_comb begin
    alu_op   = '0;
    op_class = CLS_BINARY;
    legal    = 1'b1;
    case (opcode)
      OP_ADD:  alu_op[BIT_ADD]  = 1'b1;
      OP_SUB:  alu_op[BIT_SUB]  = 1'b1;
      OP_AND:  alu_op[BIT_AND]  = 1'b1;
      OP_OR:   alu_op[BIT_OR]   = 1'b1;
      OP_SHR:  alu_op[BIT_SHR]  = 1'b1;
      OP_SHRA: alu_op[BIT_SHRA] = 1'b1;
      OP_SHL:  alu_op[BIT_SHL]  = 1'b1;
      OP_ROR:  alu_op[BIT_ROR]  = 1'b1;
      OP_ROL:  alu_op[BIT_ROL]  = 1'b1;
      OP_NEG:  begin alu_op[BIT_NEG] = 1'b1; op_class = CLS_UNARY; end
      OP_NOT:  begin alu_op[BIT_NOT] = 1'b1; op_class = CLS_UNARY; end
      OP_MUL:  begin alu_op[BIT_MUL] = 1'b1; op_class = CLS_WIDE;  end
      OP_DIV:  begin alu_op[BIT_DIV] = 1'b1; op_class = CLS_WIDE;  end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Moore control sequencer that steps one ALU instruction through the
// Y / OP / Z-low / Z-high datapath phases.
import alu_seq_pkg::*;

module alu_op_sequencer #(
  parameter int unsigned N_OPS = 15
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [OPC_W-1:0] opcode,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [N_OPS-1:0] alu_op,
  output logic             gra,
  output logic             grb,
  output logic             grc,
  output logic             rout,
  output logic             rin,
  output logic             yin,
  output logic             zin,
  output logic             zlowout,
  output logic             zhighout,
  output logic             loin,
  output logic             hiin
);

  state_e           r_state;
  state_e           w_next;
  logic [OPC_W-1:0] r_opcode;
  logic [OPC_W-1:0] w_dec_in;
  logic [N_OPS-1:0] w_dec_op;
  op_class_e        w_class;
  logic             w_legal;

  // One decoder serves both the IDLE legality check (live opcode) and the
  // later phases (latched opcode); IDLE drives no outputs, so they stay Moore.
  assign w_dec_in = (r_state == S_IDLE) ? opcode : r_opcode;

  alu_op_decode #(.N_OPS(N_OPS)) u_decode (
    .opcode   (w_dec_in),
    .alu_op   (w_dec_op),
    .op_class (w_class),
    .legal    (w_legal)
  );

  // State register and opcode latch; clr forces IDLE at once
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state  <= S_IDLE;
      r_opcode <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && start) r_opcode <= opcode;
    end
  end

  // Next-state selection
  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:  w_next = start ? (w_legal ? S_T_Y : S_ERR) : S_IDLE;
      S_T_Y:   w_next = S_T_OP;
      S_T_OP:  w_next = S_T_ZLO;
      S_T_ZLO: w_next = (w_class == CLS_WIDE) ? S_T_ZHI : S_DONE;
      S_T_ZHI: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output decode from registered state and latched opcode class
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    alu_op   = '0;
    gra      = 1'b0;
    grb      = 1'b0;
    grc      = 1'b0;
    rout     = 1'b0;
    rin      = 1'b0;
    yin      = 1'b0;
    zin      = 1'b0;
    zlowout  = 1'b0;
    zhighout = 1'b0;
    loin     = 1'b0;
    hiin     = 1'b0;
    case (r_state)
      S_IDLE: ;
      S_T_Y: begin
        busy = 1'b1;
        rout = 1'b1;
        yin  = 1'b1;
        if (w_class == CLS_WIDE) gra = 1'b1;
        else                     grb = 1'b1;
      end
      S_T_OP: begin
        busy   = 1'b1;
        alu_op = w_dec_op;
        zin    = 1'b1;
        case (w_class)
          CLS_BINARY: begin grc = 1'b1; rout = 1'b1; end
          CLS_WIDE:   begin grb = 1'b1; rout = 1'b1; end
          default: ;
        endcase
      end
      S_T_ZLO: begin
        busy    = 1'b1;
        zlowout = 1'b1;
        if (w_class == CLS_WIDE) loin = 1'b1;
        else begin
          gra = 1'b1;
          rin = 1'b1;
        end
      end
      S_T_ZHI: begin
        busy     = 1'b1;
        zhighout = 1'b1;
        hiin     = 1'b1;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      S_ERR: begin
        busy = 1'b1;
        err  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer: vector table, corner-case sequences and
// randomized traffic against a per-instruction trace model.
module tb_alu_op_sequencer;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        err;
    logic [14:0] alu_op;
    logic        gra;
    logic        grb;
    logic        grc;
    logic        rout;
    logic        rin;
    logic        yin;
    logic        zin;
    logic        zlowout;
    logic        zhighout;
    logic        loin;
    logic        hiin;
  } outs_t;

  typedef struct {
    logic [4:0]  op;
    int          lat;
    logic [14:0] op_exp;
    int          err_c;
  } vec_t;

  logic        clk;
  logic        clr;
  logic        start;
  logic [4:0]  opcode;
  logic        busy, done, err;
  logic [14:0] alu_op;
  logic        gra, grb, grc, rout, rin, yin, zin;
  logic        zlowout, zhighout, loin, hiin;

  outs_t cur;
  outs_t last;
  outs_t exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  alu_op_sequencer #(.N_OPS(15)) dut (
    .clk      (clk),
    .clr      (clr),
    .start    (start),
    .opcode   (opcode),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .alu_op   (alu_op),
    .gra      (gra),
    .grb      (grb),
    .grc      (grc),
    .rout     (rout),
    .rin      (rin),
    .yin      (yin),
    .zin      (zin),
    .zlowout  (zlowout),
    .zhighout (zhighout),
    .loin     (loin),
    .hiin     (hiin)
  );

  assign cur = {busy, done, err, alu_op, gra, grb, grc, rout, rin, yin, zin,
                zlowout, zhighout, loin, hiin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Expected per-cycle outputs of one accepted instruction, built from the
  // class rules: illegal -> one error cycle; otherwise Y, OP, Zlo, [Zhi], done.
  function automatic void push_trace(input logic [4:0] op);
    outs_t o;
    bit    wide, unary;
    if (op > 5'h0C) begin
      o = '0; o.busy = 1'b1; o.err = 1'b1; exp_q.push_back(o);
      return;
    end
    wide  = (op == 5'h0B) || (op == 5'h0C);
    unary = (op == 5'h09) || (op == 5'h0A);
    o = '0; o.busy = 1'b1; o.rout = 1'b1; o.yin = 1'b1;
    if (wide) o.gra = 1'b1; else o.grb = 1'b1;
    exp_q.push_back(o);
    o = '0; o.busy = 1'b1; o.alu_op = 15'(1) << op; o.zin = 1'b1;
    if (wide)        begin o.grb = 1'b1; o.rout = 1'b1; end
    else if (!unary) begin o.grc = 1'b1; o.rout = 1'b1; end
    exp_q.push_back(o);
    o = '0; o.busy = 1'b1; o.zlowout = 1'b1;
    if (wide) o.loin = 1'b1; else begin o.gra = 1'b1; o.rin = 1'b1; end
    exp_q.push_back(o);
    if (wide) begin
      o = '0; o.busy = 1'b1; o.zhighout = 1'b1; o.hiin = 1'b1;
      exp_q.push_back(o);
    end
    o = '0; o.busy = 1'b1; o.done = 1'b1;
    exp_q.push_back(o);
  endfunction

  // Sample at negedge, compare with model, advance model, return after posedge
  task automatic cycle_check(input string name);
    outs_t e;
    @(negedge clk);
    last = cur;
    e = (exp_q.size() != 0) ? exp_q[0] : '0;
    check(name, {3'b0, cur}, {3'b0, e});
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    else if (start) push_trace(opcode);
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [4:0] op, output int done_c, output int err_c,
                           output logic [14:0] op_seen);
    bit fin;
    done_c = 0; err_c = 0; op_seen = '0; fin = 1'b0;
    start = 1'b1; opcode = op;
    cycle_check("accept");
    start = 1'b0; opcode = 5'($urandom);
    for (int c = 1; c <= 8 && !fin; c++) begin
      cycle_check("trace");
      if (last.alu_op != '0) op_seen = last.alu_op;
      if (last.done) begin done_c = c; fin = 1'b1; end
      if (last.err)  begin err_c  = c; fin = 1'b1; end
    end
  endtask

  initial begin
    vec_t        vecs[11];
    int          dc, ec;
    logic [14:0] os;
    int          n_done, first, prev;
    bit          spacing_ok;

    vecs[0]  = '{5'h00, 4, 15'h0001, 0};
    vecs[1]  = '{5'h01, 4, 15'h0002, 0};
    vecs[2]  = '{5'h06, 4, 15'h0040, 0};
    vecs[3]  = '{5'h08, 4, 15'h0100, 0};
    vecs[4]  = '{5'h09, 4, 15'h0200, 0};
    vecs[5]  = '{5'h0A, 4, 15'h0400, 0};
    vecs[6]  = '{5'h0B, 5, 15'h0800, 0};
    vecs[7]  = '{5'h0C, 5, 15'h1000, 0};
    vecs[8]  = '{5'h0D, 0, 15'h0000, 1};
    vecs[9]  = '{5'h0E, 0, 15'h0000, 1};
    vecs[10] = '{5'h1F, 0, 15'h0000, 1};

    clr = 1'b0; start = 1'b0; opcode = 5'h00;
    #12;
    check("reset_outputs", {3'b0, cur}, 32'h0);
    @(posedge clk); #1;
    clr = 1'b1;
    cycle_check("idle_after_reset");

    // Vector table: latency, strobe bit and error pulse per opcode
    foreach (vecs[i]) begin
      run_instr(vecs[i].op, dc, ec, os);
      check($sformatf("vec%0d_done_cycle", i), 32'(dc), 32'(vecs[i].lat));
      check($sformatf("vec%0d_err_cycle", i), 32'(ec), 32'(vecs[i].err_c));
      check($sformatf("vec%0d_alu_op", i), {17'b0, os}, {17'b0, vecs[i].op_exp});
    end
    cycle_check("idle_gap");

    // start held high with ADD: one instruction every 5 cycles
    n_done = 0; first = -1; prev = -1; spacing_ok = 1'b1;
    start = 1'b1; opcode = 5'h00;
    for (int c = 0; c < 20; c++) begin
      cycle_check("held");
      if (last.done) begin
        if (first < 0) first = c;
        if (prev >= 0 && c - prev != 5) spacing_ok = 1'b0;
        prev = c;
        n_done++;
      end
    end
    start = 1'b0;
    check("held_done_count", 32'(n_done), 32'd4);
    check("held_first_done", 32'(first), 32'd4);
    check("held_spacing", {31'b0, spacing_ok}, 32'd1);
    for (int i = 0; i < 8 && exp_q.size() != 0; i++) cycle_check("held_drain");
    cycle_check("held_idle");

    // clr during T_OP of DIV, then SUB runs normally
    start = 1'b1; opcode = 5'h0C;
    cycle_check("div_accept");
    start = 1'b0;
    cycle_check("div_ty");
    #2;
    check("div_in_top", {17'b0, cur.alu_op}, 32'h1000);
    clr = 1'b0;
    #1;
    check("clr_async_outputs", {3'b0, cur}, 32'h0);
    exp_q.delete();
    @(posedge clk); #1;
    check("clr_held_outputs", {3'b0, cur}, 32'h0);
    @(posedge clk); #1;
    clr = 1'b1;
    run_instr(5'h01, dc, ec, os);
    check("sub_after_clr_done", 32'(dc), 32'd4);
    check("sub_after_clr_alu_op", {17'b0, os}, 32'h0002);

    // Randomized traffic, start also toggled while busy
    for (int i = 0; i < 400; i++) begin
      start = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 9) < 7) opcode = 5'($urandom_range(0, 12));
      else                          opcode = 5'($urandom_range(13, 31));
      cycle_check("random");
    end
    start = 1'b0;
    for (int i = 0; i < 8 && exp_q.size() != 0; i++) cycle_check("random_drain");
    cycle_check("final_idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
